// File: rtl/dsp_det_pkg.sv
// Shared constants and types for detector-style stages that run off the f_s sample pulse.
package dsp_det_pkg;

  localparam int DEF_WIN_LOG2 = 8;
  localparam int DEF_DEB      = 3;
  localparam int THR_W        = 32;
  localparam int DC_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_RELEASING = 2'd3
  } det_state_t;

endpackage

// File: rtl/fs_strobe.sv
// Synchronises the f_s sample pulse and emits a one-clk strobe two clks after each
// rising edge, by which time the upstream sample is settled.
module fs_strobe (
  input  logic clk,
  input  logic rst,
  input  logic f_s,
  output logic stb
);

  logic p0;
  logic p1;
  logic p2;

  // Three-flop chain: p0/p1 synchronise, p2 delays for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0 <= 1'b0;
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      p0 <= f_s;
      p1 <= p0;
      p2 <= p1;
    end
  end

  assign stb = p1 & ~p2;

endmodule

// File: rtl/tone_power_detector.sv
// Tone power detector: mean of din^2 over 2^WIN_LOG2 samples, followed by a
// debounced hysteresis detector on that mean.
//
// state        | meaning
// ST_IDLE      | no tone, waiting for a window >= thr_on
// ST_ARMING    | no tone yet, counting consecutive windows >= thr_on
// ST_ACTIVE    | tone present, waiting for a window < thr_off
// ST_RELEASING | tone still flagged, counting consecutive windows < thr_off
module tone_power_detector
  import dsp_det_pkg::*;
#(
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int DEB      = DEF_DEB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_s,
  input  logic              en,
  input  logic signed [15:0] din,
  input  logic [THR_W-1:0]  thr_on,
  input  logic [THR_W-1:0]  thr_off,
  output logic [THR_W-1:0]  power,
  output logic              power_valid,
  output logic              detect,
  output logic              detect_rise
);

  localparam int ACC_W = THR_W + WIN_LOG2;

  logic                      stb;
  logic                      v1;
  logic                      v2;
  logic signed [15:0]        din_q;
  logic signed [31:0]        prod;
  logic [31:0]               sq;
  logic [ACC_W-1:0]          acc;
  logic [ACC_W-1:0]          acc_sum;
  logic [WIN_LOG2-1:0]       cnt;
  logic [DC_W-1:0]           dc;
  logic [DC_W-1:0]           dc_inc;
  det_state_t                state;

  fs_strobe u_fs_strobe (
    .clk (clk),
    .rst (rst),
    .f_s (f_s),
    .stb (stb)
  );

  // Square is always non-negative and at most 2^30, so the signed product fits 32 bits.
  assign prod    = 32'(din_q) * 32'(din_q);
  assign acc_sum = acc + ACC_W'(sq);
  assign dc_inc  = dc + DC_W'(1);

  // Capture and square stages; a strobe with en low never enters the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      din_q <= '0;
      sq    <= '0;
    end else begin
      v1 <= stb & en;
      v2 <= v1;
      if (stb && en) din_q <= din;
      if (v1) sq <= $unsigned(prod);
    end
  end

  // Window accumulation; the last sample of a window publishes the truncated mean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      cnt         <= '0;
      power       <= '0;
      power_valid <= 1'b0;
    end else begin
      power_valid <= 1'b0;
      if (v2) begin
        if (cnt == '1) begin
          power       <= acc_sum[WIN_LOG2 +: THR_W];
          acc         <= '0;
          cnt         <= '0;
          power_valid <= 1'b1;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + WIN_LOG2'(1);
        end
      end
    end
  end

  // Debounce FSM, stepped once per new power value, with registered detect flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      dc          <= '0;
      detect      <= 1'b0;
      detect_rise <= 1'b0;
    end else begin
      detect_rise <= 1'b0;
      if (power_valid) begin
        case (state)
          ST_IDLE: begin
            if (power >= thr_on) begin
              if (DEB == 1) begin
                state       <= ST_ACTIVE;
                detect      <= 1'b1;
                detect_rise <= 1'b1;
              end else begin
                state <= ST_ARMING;
                dc    <= DC_W'(1);
              end
            end
          end
          ST_ARMING: begin
            if (power >= thr_on) begin
              dc <= dc_inc;
              if (dc_inc == DC_W'(DEB)) begin
                state       <= ST_ACTIVE;
                detect      <= 1'b1;
                detect_rise <= 1'b1;
              end
            end else begin
              state <= ST_IDLE;
              dc    <= '0;
            end
          end
          ST_ACTIVE: begin
            if (power < thr_off) begin
              if (DEB == 1) begin
                state  <= ST_IDLE;
                detect <= 1'b0;
              end else begin
                state <= ST_RELEASING;
                dc    <= DC_W'(1);
              end
            end
          end
          ST_RELEASING: begin
            if (power < thr_off) begin
              dc <= dc_inc;
              if (dc_inc == DC_W'(DEB)) begin
                state  <= ST_IDLE;
                detect <= 1'b0;
              end
            end else begin
              state <= ST_ACTIVE;
              dc    <= '0;
            end
          end
          default: begin
            state <= ST_IDLE;
            dc    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_power_detector.sv
// Bench for tone_power_detector with WIN_LOG2=4, DEB=2.
module tb_tone_power_detector;

  localparam int W   = 4;
  localparam int NW  = 16;
  localparam int DB  = 2;

  logic               clk;
  logic               rst;
  logic               f_s;
  logic               en;
  logic signed [15:0] din;
  logic [31:0]        thr_on;
  logic [31:0]        thr_off;
  logic [31:0]        power;
  logic               power_valid;
  logic               detect;
  logic               detect_rise;

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;
  int rise_cnt = 0;
  bit run_chk = 0;

  // model state
  longint      m_sum = 0;
  int          m_cnt = 0;
  int          m_run = 0;
  bit          m_det_fut = 0;
  bit          m_det = 0;
  bit          m_rise = 0;
  logic [31:0] m_power = 0;
  bit          pv_sched[int];
  logic [31:0] pw_sched[int];
  bit          det_sched[int];

  tone_power_detector #(.WIN_LOG2(W), .DEB(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .f_s         (f_s),
    .en          (en),
    .din         (din),
    .thr_on      (thr_on),
    .thr_off     (thr_off),
    .power       (power),
    .power_valid (power_valid),
    .detect      (detect),
    .detect_rise (detect_rise)
  );

  initial clk = 0;
  always #50 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  // Per-cycle comparison against the scheduled model timeline.
  always @(negedge clk) begin
    if (run_chk) begin
      bit exp_pv;
      exp_pv = pv_sched.exists(cyc);
      if (exp_pv) m_power = pw_sched[cyc];
      if (det_sched.exists(cyc)) begin
        m_rise = det_sched[cyc] & ~m_det;
        m_det  = det_sched[cyc];
      end else begin
        m_rise = 0;
      end
      check("power_valid", 32'(power_valid), 32'(exp_pv));
      check("power", power, m_power);
      check("detect", 32'(detect), 32'(m_det));
      check("detect_rise", 32'(detect_rise), 32'(m_rise));
      if (detect_rise) rise_cnt++;
    end
  end

  // One f_s period (11 clks); the model folds enabled samples into windows.
  task automatic sample(input logic signed [15:0] d, input logic e);
    int k;
    @(negedge clk); #5;
    din = d; en = e; f_s = 1'b1;
    k = cyc + 1;
    if (e) begin
      m_sum += longint'(d) * longint'(d);
      m_cnt++;
      if (m_cnt == NW) begin
        logic [31:0] p;
        p = 32'(m_sum / NW);
        pv_sched[k + 4] = 1'b1;
        pw_sched[k + 4] = p;
        if (!m_det_fut) begin
          if (p >= thr_on) m_run++; else m_run = 0;
        end else begin
          if (p < thr_off) m_run++; else m_run = 0;
        end
        if (m_run == DB) begin
          m_det_fut = ~m_det_fut;
          m_run = 0;
        end
        det_sched[k + 5] = m_det_fut;
        m_sum = 0;
        m_cnt = 0;
      end
    end
    repeat (4) @(negedge clk);
    #5 f_s = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic window(input logic signed [15:0] d);
    for (int i = 0; i < NW; i++) sample(d, 1'b1);
  endtask

  initial begin
    rst = 0; f_s = 0; en = 0; din = 0;
    thr_on = 32'd500000; thr_off = 32'd250000;
    repeat (3) @(negedge clk);
    check("rst_power", power, 32'd0);
    check("rst_pv", 32'(power_valid), 32'd0);
    check("rst_detect", 32'(detect), 32'd0);
    check("rst_rise", 32'(detect_rise), 32'd0);
    #5 rst = 1; run_chk = 1;
    repeat (3) @(negedge clk);

    window(16'sd1000);
    check("win1000_power", power, 32'd1000000);
    check("win1000_no_detect", 32'(detect), 32'd0);

    window(16'sd0);
    check("win0_power", power, 32'd0);
    check("arm_abort_detect", 32'(detect), 32'd0);

    window(-16'sd32768);
    check("max_neg_power", power, 32'h40000000);

    window(16'sd1000);
    check("detect_set", 32'(detect), 32'd1);
    check("one_rise", 32'(rise_cnt), 32'd1);

    window(16'sd0);
    window(16'sd1000);
    check("release_abort_detect", 32'(detect), 32'd1);

    for (int i = 0; i < 8; i++) sample(16'sd1000, 1'b1);
    for (int i = 0; i < 4; i++) sample(16'sd30000, 1'b0);
    for (int i = 0; i < 8; i++) sample(16'sd1000, 1'b1);
    check("en_gap_power", power, 32'd1000000);

    for (int i = 0; i < 7; i++) sample(16'sd1000, 1'b1);
    @(negedge clk); #5 rst = 0;
    m_sum = 0; m_cnt = 0; m_run = 0; m_det_fut = 0;
    m_det = 0; m_rise = 0; m_power = 0;
    pv_sched.delete(); pw_sched.delete(); det_sched.delete();
    #1;
    check("async_rst_power", power, 32'd0);
    check("async_rst_detect", 32'(detect), 32'd0);
    check("async_rst_pv", 32'(power_valid), 32'd0);
    repeat (2) @(negedge clk);
    #5 rst = 1;

    window(16'sd2000);
    check("post_rst_power", power, 32'd4000000);
    window(16'sd1000);
    check("post_rst_detect", 32'(detect), 32'd1);

    for (int i = 0; i < NW; i++) sample(16'(i * 2047 - 15000), 1'b1);

    window(16'sd0);
    window(16'sd0);
    check("detect_fall", 32'(detect), 32'd0);
    check("rise_total", 32'(rise_cnt), 32'd2);

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
